// File: rtl/sti_pkg.sv
// Shared types for the serial-to-parallel receiver: length codes, FSM states,
// the FIFO entry layout and the bit-count classifier.
package sti_pkg;

    localparam logic [1:0] LEN_8  = 2'd0;
    localparam logic [1:0] LEN_16 = 2'd1;
    localparam logic [1:0] LEN_24 = 2'd2;
    localparam logic [1:0] LEN_32 = 2'd3;

    localparam int WORD_W = 35;

    typedef enum logic {
        ST_IDLE,
        ST_RX
    } state_t;

    typedef struct packed {
        logic        err;
        logic [1:0]  len;
        logic [31:0] data;
    } word_t;

    typedef struct packed {
        logic       err;
        logic [1:0] len;
    } len_err_t;

    // Only whole byte multiples up to 32 are legal; anything else is tagged as
    // an error and reported with the full-width length code.
    function automatic len_err_t cnt_to_len(input logic [7:0] cnt);
        len_err_t r;
        case (cnt)
            8'd8:    r = '{err: 1'b0, len: LEN_8};
            8'd16:   r = '{err: 1'b0, len: LEN_16};
            8'd24:   r = '{err: 1'b0, len: LEN_24};
            8'd32:   r = '{err: 1'b0, len: LEN_32};
            default: r = '{err: 1'b1, len: LEN_32};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sti_word_fifo.sv
// Show-ahead FIFO for assembled words; the head entry is always presented on
// head, and pushes while full are accepted only if a pop frees a slot.
module sti_word_fifo
    import sti_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  word_t       push_data,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output word_t       head
);

    localparam int AW = $clog2(DEPTH);

    word_t          mem_q [DEPTH];
    word_t          mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q,  count_d;
    logic           push_ok;
    logic           pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sti_deserializer.sv
// Reassembles each contiguous si_valid burst into a right-justified word with a
// length code and queues it for a valid/ready consumer.
module sti_deserializer
    import sti_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNTW  = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        si_data,
    input  logic        si_valid,
    input  logic        cfg_msb,
    output logic [31:0] po_data,
    output logic [1:0]  po_len,
    output logic        po_err,
    output logic        po_valid,
    input  logic        po_ready,
    output logic        ovf,
    output logic [7:0]  frame_cnt
);

    localparam logic [CNTW-1:0] CNT_SAT = CNTW'(33);

    state_t            state_q, state_d;
    logic              ord_q, ord_d;
    logic [31:0]       sh_q, sh_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    word_t             word;
    word_t             head;
    len_err_t          le;

    always_comb begin
        state_d = state_q;
        ord_d   = ord_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (si_valid) begin
                    // Start from a clean register so error frames report only this frame's bits.
                    ord_d   = cfg_msb;
                    sh_d    = cfg_msb ? {31'b0, si_data} : {si_data, 31'b0};
                    cnt_d   = CNTW'(1);
                    state_d = ST_RX;
                end
            end
            default: begin
                if (si_valid) begin
                    sh_d = ord_q ? {sh_q[30:0], si_data} : {si_data, sh_q[31:1]};
                    if (cnt_q < CNT_SAT) cnt_d = cnt_q + CNTW'(1);
                end else begin
                    push    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        le        = cnt_to_len(8'(cnt_q));
        word.err  = le.err;
        word.len  = le.len;
        word.data = sh_q;
        if (!le.err) begin
            // LSB-first frames accumulate from the top, so legal words sit in the high bits.
            case (le.len)
                LEN_8:   word.data = ord_q ? {24'b0, sh_q[7:0]}  : {24'b0, sh_q[31:24]};
                LEN_16:  word.data = ord_q ? {16'b0, sh_q[15:0]} : {16'b0, sh_q[31:16]};
                LEN_24:  word.data = ord_q ? {8'b0,  sh_q[23:0]} : {8'b0,  sh_q[31:8]};
                default: word.data = sh_q;
            endcase
        end
    end

    assign pop = ~fifo_empty & po_ready;

    always_comb begin
        ovf_d       = ovf_q | (push & fifo_full & ~pop);
        frame_cnt_d = frame_cnt_q;
        if (push && (!fifo_full || pop)) frame_cnt_d = frame_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ord_q       <= 1'b0;
            sh_q        <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ord_q       <= ord_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    sti_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (word),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    assign po_data   = head.data;
    assign po_len    = head.len;
    assign po_err    = head.err;
    assign po_valid  = ~fifo_empty;
    assign ovf       = ovf_q;
    assign frame_cnt = frame_cnt_q;

endmodule
